// File: rtl/aes_pkg.sv
// Shared AES byte-serial definitions: block size, mixColumns enable codes,
// read-FSM state type and the ShiftRows byte-index mapping.
package aes_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam logic [7:0] COL_START_EN = 8'h00;
  localparam logic [7:0] COL_CONT_EN  = 8'hFF;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_DRAIN = 1'b1
  } rd_state_e;

  // Source index for output byte k (column-major); column offset wraps mod 4.
  function automatic logic [3:0] shift_rows_idx(input logic [3:0] k, input logic inverse);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] sc;
    r  = k[1:0];
    c  = k[3:2];
    sc = inverse ? (c - r) : (c + r);
    return {sc, r};
  endfunction

endpackage

// File: rtl/shift_rows_bank.sv
// 16x8 state-byte register file: one synchronous write port, one combinational read port.
module shift_rows_bank
  import aes_pkg::*;
(
  input  logic       clk_i,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [3:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [BLOCK_BYTES];

  // Data storage carries no reset; validity is tracked by the owner's full flags.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/shift_rows_serial.sv
// Byte-serial (Inv)ShiftRows with ping-pong banks; output stream drives mixColumns directly.
// Valid/ready: in_valid has no back-pressure; out_valid is a one-cycle-per-byte strobe with no ready.
module shift_rows_serial
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic [7:0] out_enable,
  output logic       out_first,
  output rd_state_e  dbg_state_o
);

  logic [3:0] wr_cnt_q, wr_cnt_d;
  logic       wr_bank_q, wr_bank_d;
  logic [1:0] bank_full_q, bank_full_d;
  logic [1:0] full_set, full_clr;
  logic [3:0] rd_cnt_q, rd_cnt_d;
  logic       rd_bank_q, rd_bank_d;
  rd_state_e  state_q, state_d;

  logic       out_valid_q, out_valid_d;
  logic [7:0] out_byte_q, out_byte_d;
  logic [7:0] out_enable_q, out_enable_d;
  logic       out_first_q, out_first_d;

  logic       cur_bank;
  logic       pick_bank;
  logic       emit;
  logic [3:0] rd_addr;
  logic [7:0] rdata0, rdata1, rd_data;

  shift_rows_bank u_bank0 (
    .clk_i   (clock),
    .we_i    (in_valid & ~wr_bank_q),
    .waddr_i (wr_cnt_q),
    .wdata_i (in_byte),
    .raddr_i (rd_addr),
    .rdata_o (rdata0)
  );

  shift_rows_bank u_bank1 (
    .clk_i   (clock),
    .we_i    (in_valid & wr_bank_q),
    .waddr_i (wr_cnt_q),
    .wdata_i (in_byte),
    .raddr_i (rd_addr),
    .rdata_o (rdata1)
  );

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    full_set  = 2'b00;
    if (in_valid) begin
      wr_cnt_d = wr_cnt_q + 4'd1;
      if (wr_cnt_q == 4'd15) begin
        full_set[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
      end
    end
  end

  // With both banks full the older one is the bank not currently being written.
  assign pick_bank = (&bank_full_q) ? ~wr_bank_q : bank_full_q[1];
  assign cur_bank  = (state_q == RD_DRAIN) ? rd_bank_q : pick_bank;
  assign emit      = (state_q == RD_DRAIN) || (|bank_full_q);
  assign rd_addr   = shift_rows_idx(rd_cnt_q, INVERSE);
  assign rd_data   = cur_bank ? rdata1 : rdata0;

  // IDLE emits byte 0 in the same cycle it sees a full bank, giving one-cycle latency.
  always_comb begin
    state_d      = state_q;
    rd_cnt_d     = rd_cnt_q;
    rd_bank_d    = rd_bank_q;
    full_clr     = 2'b00;
    out_valid_d  = 1'b0;
    out_byte_d   = out_byte_q;
    out_enable_d = COL_START_EN;
    out_first_d  = 1'b0;
    if (emit) begin
      out_valid_d  = 1'b1;
      out_byte_d   = rd_data;
      out_enable_d = (rd_cnt_q[1:0] == 2'd0) ? COL_START_EN : COL_CONT_EN;
      out_first_d  = (rd_cnt_q == 4'd0);
      rd_cnt_d     = rd_cnt_q + 4'd1;
      rd_bank_d    = cur_bank;
      state_d      = RD_DRAIN;
      if (rd_cnt_q == 4'd15) begin
        full_clr[cur_bank] = 1'b1;
        if (bank_full_q[~cur_bank]) begin
          rd_bank_d = ~cur_bank;
        end else begin
          state_d = RD_IDLE;
        end
      end
    end
  end

  assign bank_full_d = (bank_full_q & ~full_clr) | full_set;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_cnt_q     <= 4'd0;
      wr_bank_q    <= 1'b0;
      bank_full_q  <= 2'b00;
      rd_cnt_q     <= 4'd0;
      rd_bank_q    <= 1'b0;
      state_q      <= RD_IDLE;
      out_valid_q  <= 1'b0;
      out_byte_q   <= 8'h00;
      out_enable_q <= COL_START_EN;
      out_first_q  <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      bank_full_q  <= bank_full_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_bank_q    <= rd_bank_d;
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_byte_q   <= out_byte_d;
      out_enable_q <= out_enable_d;
      out_first_q  <= out_first_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_byte    = out_byte_q;
  assign out_enable  = out_enable_q;
  assign out_first   = out_first_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_rows_serial.sv
// Bench for shift_rows_serial: forward and inverse instances, directed and random blocks
// checked against a row-rotation reference model.
module tb_shift_rows_serial;
  import aes_pkg::*;

  typedef struct packed {
    logic [7:0]  b;
    logic [7:0]  en;
    logic        first;
    logic [31:0] cyc;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       fwd_valid, inv_valid;
  logic [7:0] fwd_byte, inv_byte;
  logic       fwd_out_valid, inv_out_valid;
  logic [7:0] fwd_out_byte, inv_out_byte;
  logic [7:0] fwd_out_en, inv_out_en;
  logic       fwd_out_first, inv_out_first;
  rd_state_e  fwd_state, inv_state;

  int          total = 0;
  int          bad = 0;
  logic [31:0] cyc = 0;
  rec_t        fwd_q[$];
  rec_t        inv_q[$];
  logic [7:0]  exp_q[$];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_rows_serial #(.INVERSE(1'b0)) u_fwd (
    .clock(clk), .reset(reset), .in_valid(fwd_valid), .in_byte(fwd_byte),
    .out_valid(fwd_out_valid), .out_byte(fwd_out_byte), .out_enable(fwd_out_en),
    .out_first(fwd_out_first), .dbg_state_o(fwd_state)
  );

  shift_rows_serial #(.INVERSE(1'b1)) u_inv (
    .clock(clk), .reset(reset), .in_valid(inv_valid), .in_byte(inv_byte),
    .out_valid(inv_out_valid), .out_byte(inv_out_byte), .out_enable(inv_out_en),
    .out_first(inv_out_first), .dbg_state_o(inv_state)
  );

  // output capture, stamped with the index of the edge that registered the byte
  always @(negedge clk) begin
    if (fwd_out_valid) fwd_q.push_back('{fwd_out_byte, fwd_out_en, fwd_out_first, cyc});
    if (inv_out_valid) inv_q.push_back('{inv_out_byte, inv_out_en, inv_out_first, cyc});
  end

  // reference model: out[r+4c] = in[r+4((c+r)%4)] or in[r+4((c-r)%4)]
  function automatic logic [127:0] model(input logic [127:0] din, input bit inv);
    logic [127:0] dout;
    int src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (r + 4 * ((c - r + 4) % 4)) : (r + 4 * ((c + r) % 4));
        dout[(r + 4 * c) * 8 +: 8] = din[src * 8 +: 8];
      end
    end
    return dout;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: called at a negedge, returns at the following negedge
  task automatic drive_byte(input bit sel, input logic [7:0] b, output int edge_idx);
    if (sel) begin inv_valid = 1'b1; inv_byte = b; end
    else     begin fwd_valid = 1'b1; fwd_byte = b; end
    @(negedge clk);
    edge_idx  = cyc;
    fwd_valid = 1'b0;
    inv_valid = 1'b0;
  endtask

  task automatic send_block(input bit sel, input logic [127:0] data, input int gap,
                            output int last_edge);
    for (int k = 0; k < 16; k++) begin
      drive_byte(sel, data[k * 8 +: 8], last_edge);
      if (k != 15) repeat (gap) @(negedge clk);
    end
  endtask

  // scoreboard: 16 bytes, enable/first pattern and contiguous timing from start_edge
  task automatic check_out(input bit sel, input logic [127:0] exp_blk, input int start_edge,
                           input string tag);
    rec_t r;
    int t;
    int avail;
    t = 0;
    for (int k = 0; k < 16; k++) exp_q.push_back(exp_blk[k * 8 +: 8]);
    avail = sel ? inv_q.size() : fwd_q.size();
    while (avail < 16 && t < 200) begin
      @(negedge clk); #1;
      t++;
      avail = sel ? inv_q.size() : fwd_q.size();
    end
    chk({tag, " avail"}, (avail >= 16) ? 32'd1 : 32'd0, 32'd1);
    for (int k = 0; k < 16; k++) begin
      r = '0;
      if (sel && inv_q.size() > 0) r = inv_q.pop_front();
      else if (!sel && fwd_q.size() > 0) r = fwd_q.pop_front();
      chk($sformatf("%s byte%0d", tag, k), {24'd0, r.b}, {24'd0, exp_q.pop_front()});
      chk($sformatf("%s en%0d", tag, k), {24'd0, r.en}, (k % 4 == 0) ? 32'h00 : 32'hFF);
      chk($sformatf("%s first%0d", tag, k), {31'd0, r.first}, (k == 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s cyc%0d", tag, k), r.cyc, start_edge + k);
    end
  endtask

  initial begin
    logic [127:0] fips_in, fips_out, gap_in, gap_out, b1, b2, b3;
    int e1, e2, e3, t, dummy;
    fips_in  = 128'h3052411ee55db4b8f198bfe0ae1127d4;
    fips_out = 128'he598271ef11141b8ae52b4e0305dbfd4;
    gap_in   = 128'h0f0e0d0c0b0a09080706050403020100;
    gap_out  = 128'h0b06010c07020d08030e09040f0a0500;

    fwd_valid = 1'b0; inv_valid = 1'b0; fwd_byte = 8'h00; inv_byte = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst fwd valid", {31'd0, fwd_out_valid}, 32'd0);
    chk("rst fwd byte", {24'd0, fwd_out_byte}, 32'h00);
    chk("rst fwd en", {24'd0, fwd_out_en}, 32'h00);
    chk("rst fwd first", {31'd0, fwd_out_first}, 32'd0);
    chk("rst inv valid", {31'd0, inv_out_valid}, 32'd0);
    chk("rst fwd state", {31'd0, fwd_state}, {31'd0, RD_IDLE});
    reset = 1'b0;
    @(negedge clk);

    // FIPS-197 round 1 ShiftRows, then inverse restores the input
    send_block(1'b0, fips_in, 0, e1);
    check_out(1'b0, fips_out, e1 + 1, "fips fwd");
    send_block(1'b1, fips_out, 0, e1);
    check_out(1'b1, fips_in, e1 + 1, "fips inv");

    // three random blocks back-to-back
    b1 = rand_block(); b2 = rand_block(); b3 = rand_block();
    send_block(1'b0, b1, 0, e1);
    send_block(1'b0, b2, 0, e2);
    send_block(1'b0, b3, 0, e3);
    check_out(1'b0, model(b1, 1'b0), e1 + 1, "b2b blk0");
    check_out(1'b0, model(b2, 1'b0), e1 + 17, "b2b blk1");
    check_out(1'b0, model(b3, 1'b0), e1 + 33, "b2b blk2");
    chk("b2b edge spacing", e3 - e1, 32);

    // random inverse block with random gaps
    b1 = rand_block();
    send_block(1'b1, b1, $urandom_range(1, 3), e1);
    check_out(1'b1, model(b1, 1'b1), e1 + 1, "rand inv gap");

    // every-other-cycle input 00..0f
    send_block(1'b0, gap_in, 1, e1);
    check_out(1'b0, gap_out, e1 + 1, "gapped");

    // reset after 9 bytes discards the partial block
    b1 = rand_block();
    for (int k = 0; k < 9; k++) drive_byte(1'b0, b1[k * 8 +: 8], dummy);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("partial no output", fwd_q.size(), 0);
    b2 = rand_block();
    send_block(1'b0, b2, 0, e1);
    check_out(1'b0, model(b2, 1'b0), e1 + 1, "after partial");

    // reset mid-drain at output byte 6
    b1 = rand_block();
    send_block(1'b0, b1, 0, e1);
    t = 0;
    while (fwd_q.size() < 7 && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    chk("drain reached byte6", fwd_q.size(), 7);
    reset = 1'b1;
    #1;
    chk("mid rst valid", {31'd0, fwd_out_valid}, 32'd0);
    chk("mid rst en", {24'd0, fwd_out_en}, 32'h00);
    @(negedge clk);
    reset = 1'b0;
    fwd_q.delete();
    repeat (25) @(negedge clk);
    #1;
    chk("no output after rst", fwd_q.size(), 0);
    b2 = rand_block();
    send_block(1'b0, b2, 0, e1);
    check_out(1'b0, model(b2, 1'b0), e1 + 1, "after mid rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
